// File: rtl/pipeline_ctrl_pkg.sv
// Shared stall codes, reset level and EX-counter state type for the pipeline stall controller.
// The priority encoder lives here so the top level and any checker agree on the codes.
package pipeline_ctrl_pkg;

  localparam logic RST_ENABLE = 1'b1;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    EX_IDLE = 1'b0,
    EX_BUSY = 1'b1
  } ex_state_t;

  // Later stages win: a stall in stage k freezes every stage before it.
  function automatic logic [5:0] stall_code(input logic mem, input logic ex,
                                            input logic id, input logic fetch);
    if (mem)        return STALL_MEM;
    else if (ex)    return STALL_EX;
    else if (id)    return STALL_ID;
    else if (fetch) return STALL_IF;
    else            return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Request/response bundle between the pipeline stages and the stall controller.
// mem_req/mem_ack: an access completes in the cycle mem_ack=1; until then MEM is stalled.
interface pipeline_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
);
  logic             stallreq_if;
  logic             stallreq_id;
  logic             ex_mc_start;
  logic [CNT_W-1:0] ex_mc_cycles;
  logic             mem_req;
  logic             mem_ack;
  logic [5:0]       stall;
  logic             ex_mc_busy;
  logic             ex_mc_done;
  logic             mem_wait;
  logic             mem_timeout;
  ex_state_t        ex_state;

  modport master (
    output stallreq_if, stallreq_id, ex_mc_start, ex_mc_cycles, mem_req, mem_ack,
    input  stall, ex_mc_busy, ex_mc_done, mem_wait, mem_timeout, ex_state
  );

  modport slave (
    input  stallreq_if, stallreq_id, ex_mc_start, ex_mc_cycles, mem_req, mem_ack,
    output stall, ex_mc_busy, ex_mc_done, mem_wait, mem_timeout, ex_state
  );
endinterface

// File: rtl/pipeline_ctrl_ex_mc_counter.sv
// EX multi-cycle op tracker: accepts a start, counts down N cycles, pulses done once.
// freeze holds the count and suppresses done while a later stage is stalled.
module pipeline_ctrl_ex_mc_counter
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cycles,
  input  logic             freeze,
  output logic             busy,
  output logic             done,
  output logic             ex_stall,
  output ex_state_t        state
);

  ex_state_t        state_n;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_n;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= EX_IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      cnt_q <= cnt_n;
    end
  end

  // The start cycle itself counts as cycle 1, so the counter is loaded with N-2.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt_q;
    done     = 1'b0;
    ex_stall = 1'b0;
    case (state)
      EX_IDLE: begin
        if (start && !freeze) begin
          if (cycles <= CNT_W'(1)) begin
            done = 1'b1;
          end else begin
            ex_stall = 1'b1;
            cnt_n    = cycles - CNT_W'(2);
            state_n  = EX_BUSY;
          end
        end
      end
      EX_BUSY: begin
        if (!freeze) begin
          if (cnt_q != '0) begin
            ex_stall = 1'b1;
            cnt_n    = cnt_q - CNT_W'(1);
          end else begin
            done    = 1'b1;
            state_n = EX_IDLE;
          end
        end
      end
      default: state_n = EX_IDLE;
    endcase
  end

  assign busy = (state == EX_BUSY);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall vector producer: merges IF/ID/EX/MEM stall requests, tracks the MEM wait
// with an optional timeout, and hosts the EX multi-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W  = 6,
  parameter int MEM_TO = 255
) (
  input logic           clk,
  input logic           rst,
  pipeline_ctrl_if.slave bus
);

  localparam int              TO_W    = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TO > 0) ? MEM_TO - 1 : 0);
  localparam logic            TO_EN   = (MEM_TO > 0);

  logic            mem_wait_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            mem_pending;
  logic            timeout;
  logic            mem_stall;
  logic            run;
  logic            ex_busy;
  logic            ex_done;
  logic            ex_stall;
  ex_state_t       ex_state;

  assign run         = (rst != RST_ENABLE);
  assign mem_pending = (bus.mem_req | mem_wait_q) & ~bus.mem_ack;
  assign timeout     = TO_EN & mem_wait_q & ~bus.mem_ack & (to_cnt_q == TO_LAST);
  // A timed-out access releases the pipeline in the same cycle it is abandoned.
  assign mem_stall   = mem_pending & ~timeout;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      mem_wait_q <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      mem_wait_q <= mem_stall;
      if (mem_wait_q && !bus.mem_ack && !timeout) to_cnt_q <= to_cnt_q + TO_W'(1);
      else                                        to_cnt_q <= '0;
    end
  end

  pipeline_ctrl_ex_mc_counter #(.CNT_W(CNT_W)) u_ex_mc_counter (
    .clk      (clk),
    .rst      (rst),
    .start    (bus.ex_mc_start),
    .cycles   (bus.ex_mc_cycles),
    .freeze   (mem_stall),
    .busy     (ex_busy),
    .done     (ex_done),
    .ex_stall (ex_stall),
    .state    (ex_state)
  );

  assign bus.stall       = run ? stall_code(mem_stall, ex_stall, bus.stallreq_id, bus.stallreq_if)
                               : STALL_NONE;
  assign bus.ex_mc_busy  = run & ex_busy;
  assign bus.ex_mc_done  = run & ex_done;
  assign bus.mem_wait    = run & mem_stall;
  assign bus.mem_timeout = run & timeout;
  assign bus.ex_state    = ex_state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (MEM_TO=4): inputs change 1 time unit after posedge,
// outputs are checked 1 time unit later against hand-computed vectors.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_seen   = 0;
  int   to_seen     = 0;

  pipeline_ctrl_if #(.CNT_W(6)) bus ();

  pipeline_ctrl #(.CNT_W(6), .MEM_TO(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ex_mc_done)  done_seen++;
    if (bus.mem_timeout) to_seen++;
  end

  function automatic logic [9:0] e(input logic [5:0] s, input logic b, input logic d,
                                   input logic w, input logic t);
    return {s, b, d, w, t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] expv);
    logic [9:0] obs;
    #1;
    obs = {bus.stall, bus.ex_mc_busy, bus.ex_mc_done, bus.mem_wait, bus.mem_timeout};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed stall=%b busy,done,wait,timeout=%b expected stall=%b busy,done,wait,timeout=%b",
             tag, obs[9:4], obs[3:0], expv[9:4], expv[3:0]);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.stallreq_if = 1'b0; bus.stallreq_id = 1'b0; bus.ex_mc_start = 1'b0;
    bus.ex_mc_cycles = 6'd0; bus.mem_req = 1'b0; bus.mem_ack = 1'b0;

    // Reset forces outputs low even with requests present
    step(); bus.stallreq_if = 1'b1; bus.mem_req = 1'b1;
    chk("reset_forced", e(STALL_NONE, 0, 0, 0, 0));
    step(); rst = 1'b0; bus.stallreq_if = 1'b0; bus.mem_req = 1'b0;
    chk("post_reset_idle", e(6'b000000, 0, 0, 0, 0));

    // Plain IF / ID requests, no state involved
    step(); bus.stallreq_if = 1'b1; chk("if_req", e(6'b000011, 0, 0, 0, 0));
    step(); bus.stallreq_if = 1'b0; bus.stallreq_id = 1'b1; chk("id_req", e(6'b000111, 0, 0, 0, 0));
    step(); bus.stallreq_if = 1'b1; chk("if_and_id", e(6'b000111, 0, 0, 0, 0));
    step(); bus.stallreq_if = 1'b0; bus.stallreq_id = 1'b0; chk("no_req", e(6'b000000, 0, 0, 0, 0));

    // EX op N=5: stall cycles 1-4, done cycle 5, busy cycles 2-5
    step(); bus.ex_mc_start = 1'b1; bus.ex_mc_cycles = 6'd5;
    chk("n5_c1", e(6'b001111, 0, 0, 0, 0));
    step(); chk("n5_c2", e(6'b001111, 1, 0, 0, 0));
    step(); chk("n5_c3", e(6'b001111, 1, 0, 0, 0));
    step(); chk("n5_c4", e(6'b001111, 1, 0, 0, 0));
    step(); chk("n5_c5_done", e(6'b000000, 1, 1, 0, 0));
    step(); bus.ex_mc_start = 1'b0; chk("n5_after", e(6'b000000, 0, 0, 0, 0));

    // EX op N=1: done in the start cycle, no stall; ID request still honoured
    step(); bus.ex_mc_start = 1'b1; bus.ex_mc_cycles = 6'd1;
    chk("n1_done", e(6'b000000, 0, 1, 0, 0));
    step(); bus.ex_mc_start = 1'b0; bus.stallreq_id = 1'b1;
    chk("n1_after_id", e(6'b000111, 0, 0, 0, 0));

    // MEM: same-cycle ack is free; ack after 3 cycles stalls 3 cycles
    step(); bus.stallreq_id = 1'b0; bus.mem_req = 1'b1; bus.mem_ack = 1'b1;
    chk("mem_same_ack", e(6'b000000, 0, 0, 0, 0));
    step(); bus.mem_ack = 1'b0; chk("mem_w1", e(6'b011111, 0, 0, 1, 0));
    step(); chk("mem_w2", e(6'b011111, 0, 0, 1, 0));
    step(); chk("mem_w3", e(6'b011111, 0, 0, 1, 0));
    step(); bus.mem_ack = 1'b1; chk("mem_ack", e(6'b000000, 0, 0, 0, 0));
    step(); bus.mem_req = 1'b0; bus.mem_ack = 1'b0; chk("mem_idle", e(6'b000000, 0, 0, 0, 0));

    // Timeout with MEM_TO=4: pulse on the 5th cycle, MEM stall priority over IF meanwhile
    step(); bus.mem_req = 1'b1; bus.stallreq_if = 1'b1; chk("to_c1", e(6'b011111, 0, 0, 1, 0));
    step(); bus.mem_req = 1'b0; chk("to_c2", e(6'b011111, 0, 0, 1, 0));
    step(); chk("to_c3", e(6'b011111, 0, 0, 1, 0));
    step(); chk("to_c4", e(6'b011111, 0, 0, 1, 0));
    step(); chk("to_c5_pulse", e(6'b000011, 0, 0, 0, 1));
    step(); bus.stallreq_if = 1'b0; chk("to_after", e(6'b000000, 0, 0, 0, 0));

    // EX op N=6 with a 2-cycle MEM stall at cnt=2: done on cycle 8
    step(); bus.ex_mc_start = 1'b1; bus.ex_mc_cycles = 6'd6;
    chk("n6_c1", e(6'b001111, 0, 0, 0, 0));
    step(); chk("n6_c2", e(6'b001111, 1, 0, 0, 0));
    step(); chk("n6_c3", e(6'b001111, 1, 0, 0, 0));
    step(); bus.mem_req = 1'b1; chk("n6_c4_mem", e(6'b011111, 1, 0, 1, 0));
    step(); bus.mem_req = 1'b0; chk("n6_c5_mem", e(6'b011111, 1, 0, 1, 0));
    step(); bus.mem_ack = 1'b1; chk("n6_c6_ack", e(6'b001111, 1, 0, 0, 0));
    step(); bus.mem_ack = 1'b0; chk("n6_c7", e(6'b001111, 1, 0, 0, 0));
    step(); chk("n6_c8_done", e(6'b000000, 1, 1, 0, 0));
    step(); bus.ex_mc_start = 1'b0; chk("n6_after", e(6'b000000, 0, 0, 0, 0));

    // Reset in the middle of an EX op and a MEM wait
    step(); bus.ex_mc_start = 1'b1; bus.ex_mc_cycles = 6'd6;
    chk("rs_c1", e(6'b001111, 0, 0, 0, 0));
    step(); chk("rs_c2", e(6'b001111, 1, 0, 0, 0));
    step(); bus.mem_req = 1'b1; chk("rs_c3_mem", e(6'b011111, 1, 0, 1, 0));
    step(); bus.mem_req = 1'b0; rst = 1'b1; chk("rs_in_reset1", e(6'b000000, 0, 0, 0, 0));
    step(); chk("rs_in_reset2", e(6'b000000, 0, 0, 0, 0));
    step(); rst = 1'b0; bus.ex_mc_start = 1'b0; chk("rs_release", e(6'b000000, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++) begin
      step(); chk("rs_quiet", e(6'b000000, 0, 0, 0, 0));
    end

    step();
    chk_int("done_pulses", done_seen, 3);
    chk_int("timeout_pulses", to_seen, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
